// File: rtl/slurm16_cpu_registers_pkg.sv
// Shared definitions for the slurm16 register file: register roles, entry count, FSM states.
package slurm16_cpu_registers_pkg;

  localparam int REG_ZERO                = 0;
  localparam int LINK_REGISTER           = 15;
  localparam int INTERRUPT_LINK_REGISTER = 14;
  localparam int REGFILE_ENTRIES         = 128;

  typedef enum logic {
    REGFILE_STATE_CLEAR = 1'b0,
    REGFILE_STATE_RUN   = 1'b1
  } regfile_state_t;

endpackage

// File: rtl/slurm16_cpu_registers_if.sv
// Decode/writeback-facing port bundle of the register file; state_dbg mirrors the FSM.
interface slurm16_cpu_registers_if #(
  parameter int BITS          = 16,
  parameter int REGISTER_BITS = 7
);
  import slurm16_cpu_registers_pkg::*;

  logic [REGISTER_BITS-1:0] regA_sel;
  logic [REGISTER_BITS-1:0] regB_sel;
  logic                     stall;
  logic                     reg_wr_en;
  logic [REGISTER_BITS-1:0] reg_wr_sel;
  logic [BITS-1:0]          reg_wr_data;
  logic [BITS-1:0]          regA_data;
  logic [BITS-1:0]          regB_data;
  logic                     clear_busy;
  regfile_state_t           state_dbg;

  // Pipeline side drives selects and write strobes; no handshake, the
  // consumer stalls on clear_busy and the file accepts every cycle.
  modport master (
    output regA_sel, regB_sel, stall, reg_wr_en, reg_wr_sel, reg_wr_data,
    input  regA_data, regB_data, clear_busy, state_dbg
  );

  modport slave (
    input  regA_sel, regB_sel, stall, reg_wr_en, reg_wr_sel, reg_wr_data,
    output regA_data, regB_data, clear_busy, state_dbg
  );
endinterface

// File: rtl/slurm16_cpu_regfile_ram.sv
// 2R1W synchronous storage array; read ports register old contents on a same-edge write.
module slurm16_cpu_regfile_ram #(
  parameter int BITS          = 16,
  parameter int REGISTER_BITS = 7
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [REGISTER_BITS-1:0] waddr_i,
  input  logic [BITS-1:0]          wdata_i,
  input  logic                     re_i,
  input  logic [REGISTER_BITS-1:0] raddr_a_i,
  input  logic [REGISTER_BITS-1:0] raddr_b_i,
  output logic [BITS-1:0]          rdata_a_o,
  output logic [BITS-1:0]          rdata_b_o
);

  logic [BITS-1:0] mem_q [2**REGISTER_BITS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) begin
      rdata_a_o <= mem_q[raddr_a_i];
      rdata_b_o <= mem_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/slurm16_cpu_registers.sv
// slurm16 register file: post-reset clear FSM, r0 masking, stall hold, optional
// write-through bypass when SLURM16_REGFILE_BYPASS_EN is defined.
module slurm16_cpu_registers
  import slurm16_cpu_registers_pkg::*;
#(
  parameter int BITS          = 16,
  parameter int REGISTER_BITS = 7
) (
  input logic                   CLK,
  input logic                   RSTb,
  slurm16_cpu_registers_if.slave bus
);

  localparam logic [REGISTER_BITS-1:0] SEL_ZERO = REGISTER_BITS'(REG_ZERO);

  regfile_state_t           state_q, state_d;
  logic [REGISTER_BITS-1:0] cnt_q, cnt_d;
  logic                     zero_a_q, zero_a_d, zero_b_q, zero_b_d;
  logic                     ram_we, ram_re;
  logic [REGISTER_BITS-1:0] ram_waddr;
  logic [BITS-1:0]          ram_wdata, ram_a, ram_b;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q  <= REGFILE_STATE_CLEAR;
      cnt_q    <= REGISTER_BITS'(1);
      zero_a_q <= 1'b1;
      zero_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      zero_a_q <= zero_a_d;
      zero_b_q <= zero_b_d;
    end
  end

  // zero_*_q forces an output to 0 for r0 reads and throughout CLEAR, so the
  // unreset RAM read registers never leak out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    zero_a_d  = zero_a_q;
    zero_b_d  = zero_b_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = bus.reg_wr_sel;
    ram_wdata = bus.reg_wr_data;
    case (state_q)
      REGFILE_STATE_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + REGISTER_BITS'(1);
        zero_a_d  = 1'b1;
        zero_b_d  = 1'b1;
        if (cnt_q == '1) state_d = REGFILE_STATE_RUN;
      end
      default: begin
        ram_we = bus.reg_wr_en && (bus.reg_wr_sel != SEL_ZERO);
        if (!bus.stall) begin
          ram_re   = 1'b1;
          zero_a_d = (bus.regA_sel == SEL_ZERO);
          zero_b_d = (bus.regB_sel == SEL_ZERO);
        end
      end
    endcase
  end

  slurm16_cpu_regfile_ram #(
    .BITS          (BITS),
    .REGISTER_BITS (REGISTER_BITS)
  ) u_ram (
    .clk_i     (CLK),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .re_i      (ram_re),
    .raddr_a_i (bus.regA_sel),
    .raddr_b_i (bus.regB_sel),
    .rdata_a_o (ram_a),
    .rdata_b_o (ram_b)
  );

`ifdef SLURM16_REGFILE_BYPASS_EN
  logic            hit_a, hit_b;
  logic            byp_a_q, byp_b_q;
  logic [BITS-1:0] byp_data_q;

  assign hit_a = ram_we && (bus.reg_wr_sel == bus.regA_sel);
  assign hit_b = ram_we && (bus.reg_wr_sel == bus.regB_sel);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      byp_a_q    <= 1'b0;
      byp_b_q    <= 1'b0;
      byp_data_q <= '0;
    end else if (ram_re) begin
      byp_a_q <= hit_a;
      byp_b_q <= hit_b;
      if (hit_a || hit_b) byp_data_q <= bus.reg_wr_data;
    end
  end

  assign bus.regA_data = zero_a_q ? '0 : (byp_a_q ? byp_data_q : ram_a);
  assign bus.regB_data = zero_b_q ? '0 : (byp_b_q ? byp_data_q : ram_b);
`else
  assign bus.regA_data = zero_a_q ? '0 : ram_a;
  assign bus.regB_data = zero_b_q ? '0 : ram_b;
`endif

  assign bus.clear_busy = (state_q == REGFILE_STATE_CLEAR);
  assign bus.state_dbg  = state_q;

endmodule
